// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared codes and state encoding for the writeback controller
//   SRC_*  : writeback source select codes (i_src)
//   LD_*   : load size codes (i_ldsz)
//   state_t: controller states
//   load_aligned(): legality of a load size / byte offset pair
package wb_pkg;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_LOAD = 2'b01;
  localparam logic [1:0] SRC_LINK = 2'b10;

  localparam logic [1:0] LD_WORD = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAIT_MEM = 2'b01,
    WRITE    = 2'b10,
    ERR      = 2'b11
  } state_t;

  // Words must be 4-byte aligned, halves 2-byte aligned, bytes anywhere;
  // the reserved size code is never legal.
  function automatic logic load_aligned(input logic [1:0] ldsz, input logic [1:0] byteoff);
    logic ok;
    ok = 1'b0;
    case (ldsz)
      LD_WORD: ok = (byteoff == 2'b00);
      LD_HALF: ok = (byteoff[0] == 1'b0);
      LD_BYTE: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/wb_writer_if.sv
// rtl/wb_writer_if.sv - request, memory-return and register-write signals of the writeback controller
//   master: control FSM / memory / register file side (drives i_*, observes o_*)
//   slave : wb_writer side (observes i_*, drives o_*)
interface wb_writer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              i_req;
  logic              o_ready;
  logic [1:0]        i_src;
  logic [ADDR_W-1:0] i_dst;
  logic [DATA_W-1:0] i_alu;
  logic [DATA_W-1:0] i_pc;
  logic [1:0]        i_ldsz;
  logic              i_ldsgn;
  logic [1:0]        i_byteoff;
  logic              i_mem_valid;
  logic [DATA_W-1:0] i_mem_data;
  logic [ADDR_W-1:0] o_wreg;
  logic [DATA_W-1:0] o_wdata;
  logic              o_wen;
  logic              o_done;
  logic              o_err;

  modport master (
    output i_req, i_src, i_dst, i_alu, i_pc, i_ldsz, i_ldsgn, i_byteoff,
           i_mem_valid, i_mem_data,
    input  o_ready, o_wreg, o_wdata, o_wen, o_done, o_err
  );

  modport slave (
    input  i_req, i_src, i_dst, i_alu, i_pc, i_ldsz, i_ldsgn, i_byteoff,
           i_mem_valid, i_mem_data,
    output o_ready, o_wreg, o_wdata, o_wen, o_done, o_err
  );
endinterface

// File: rtl/wb_writer_load_extend.sv
// rtl/wb_writer_load_extend.sv - lane extraction and sign/zero extension of load data
//   mem_data : little-endian memory read word
//   ldsz     : LD_WORD / LD_HALF / LD_BYTE
//   ldsgn    : 1 sign-extend, 0 zero-extend (half/byte)
//   byteoff  : load address bits [1:0]
//   ext      : extended 32-bit result
module load_extend
  import wb_pkg::*;
(
  input  logic [31:0] mem_data,
  input  logic [1:0]  ldsz,
  input  logic        ldsgn,
  input  logic [1:0]  byteoff,
  output logic [31:0] ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = mem_data[{byteoff, 3'b000} +: 8];
    half_lane = byteoff[1] ? mem_data[31:16] : mem_data[15:0];
    case (ldsz)
      LD_HALF: ext = {{16{ldsgn & half_lane[15]}}, half_lane};
      LD_BYTE: ext = {{24{ldsgn & byte_lane[7]}}, byte_lane};
      default: ext = mem_data;
    endcase
  end

endmodule

// File: rtl/wb_writer.sv
// rtl/wb_writer.sv - writeback controller: one register-file write (or error) per request
//   clk  : clock, rising edge
//   rst  : synchronous active-low reset
//   bus  : wb_writer_if.slave - request (i_req/o_ready, source operands),
//          memory return (i_mem_valid/i_mem_data), register write (o_wreg/o_wdata/o_wen),
//          completion pulses (o_done/o_err)
module wb_writer
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input logic       clk,
  input logic       rst,
  wb_writer_if.slave bus
);

  state_t            state, state_next;
  logic [ADDR_W-1:0] dst_q, dst_next;
  logic [1:0]        ldsz_q, ldsz_next;
  logic              ldsgn_q, ldsgn_next;
  logic [1:0]        off_q, off_next;
  logic [7:0]        cnt_q, cnt_next;
  logic [DATA_W-1:0] wdata_next;
  logic [31:0]       load_val;

  load_extend u_load_extend (
    .mem_data (bus.i_mem_data),
    .ldsz     (ldsz_q),
    .ldsgn    (ldsgn_q),
    .byteoff  (off_q),
    .ext      (load_val)
  );

  assign bus.o_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      dst_q   <= '0;
      ldsz_q  <= '0;
      ldsgn_q <= 1'b0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_next;
      dst_q   <= dst_next;
      ldsz_q  <= ldsz_next;
      ldsgn_q <= ldsgn_next;
      off_q   <= off_next;
      cnt_q   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    dst_next   = dst_q;
    ldsz_next  = ldsz_q;
    ldsgn_next = ldsgn_q;
    off_next   = off_q;
    cnt_next   = cnt_q;
    wdata_next = '0;
    case (state)
      IDLE: begin
        if (bus.i_req) begin
          dst_next   = bus.i_dst;
          ldsz_next  = bus.i_ldsz;
          ldsgn_next = bus.i_ldsgn;
          off_next   = bus.i_byteoff;
          case (bus.i_src)
            SRC_ALU: begin
              wdata_next = bus.i_alu;
              state_next = WRITE;
            end
            SRC_LINK: begin
              wdata_next = bus.i_pc + DATA_W'(4);
              state_next = WRITE;
            end
            SRC_LOAD: begin
              cnt_next   = '0;
              state_next = load_aligned(bus.i_ldsz, bus.i_byteoff) ? WAIT_MEM : ERR;
            end
            default: state_next = ERR;
          endcase
        end
      end
      WAIT_MEM: begin
        // Data checked before the timeout so a valid on the last allowed
        // cycle still produces the write.
        if (bus.i_mem_valid) begin
          wdata_next = load_val;
          state_next = WRITE;
        end else begin
          cnt_next = cnt_q + 8'd1;
          if (cnt_next == 8'(MEM_TIMEOUT)) begin
            state_next = ERR;
          end
        end
      end
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the pulses line up with
  // the cycle the FSM spends in WRITE or ERR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.o_wen   <= 1'b0;
      bus.o_done  <= 1'b0;
      bus.o_err   <= 1'b0;
      bus.o_wreg  <= '0;
      bus.o_wdata <= '0;
    end else begin
      bus.o_wen  <= (state_next == WRITE) && (dst_next != '0);
      bus.o_done <= (state_next == WRITE);
      bus.o_err  <= (state_next == ERR);
      if (state_next == WRITE) begin
        bus.o_wreg  <= dst_next;
        bus.o_wdata <= wdata_next;
      end
    end
  end

endmodule

// File: tb/tb_wb_writer.sv
// tb/tb_wb_writer.sv - self-checking bench for wb_writer against a transaction-level model
module tb_wb_writer;

  localparam int TMO = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [4:0]  last_wreg;
  logic [31:0] last_wdata;

  wb_writer_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  wb_writer #(.DATA_W(32), .ADDR_W(5), .MEM_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, need summary");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Extracted and extended load value computed with plain arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] d, input int sz, input bit sgn, input int off);
    longint v;
    int bits;
    int shamt;
    if (sz == 0) return d;
    bits  = (sz == 1) ? 16 : 8;
    shamt = (sz == 1) ? (off / 2) * 16 : off * 8;
    v = longint'(d >> shamt) % (longint'(1) << bits);
    if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  function automatic bit model_legal(input int sz, input int off);
    if (sz == 0) return off == 0;
    if (sz == 1) return (off % 2) == 0;
    return sz == 2;
  endfunction

  task automatic check_quiet(input string tag);
    check_val({tag, "_wen"},   32'(bus.o_wen),   32'd0);
    check_val({tag, "_done"},  32'(bus.o_done),  32'd0);
    check_val({tag, "_err"},   32'(bus.o_err),   32'd0);
    check_val({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
    check_val({tag, "_wreg"},  32'(bus.o_wreg),  32'd0);
    check_val({tag, "_wdata"}, bus.o_wdata,      32'd0);
  endtask

  // delay: valid presented for the edge this many cycles after the accept edge (0 = never)
  task automatic run_txn(input logic [1:0] src, input logic [4:0] dst, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [31:0] mdata, input logic [1:0] sz,
                         input logic sgn, input logic [1:0] off, input int delay);
    bit is_err;
    bit waits;
    int resp;
    logic [31:0] exp_data;
    is_err   = 0;
    waits    = 0;
    resp     = 0;
    exp_data = '0;
    case (src)
      2'd0: exp_data = alu;
      2'd2: exp_data = pc + 32'd4;
      2'd1: begin
        if (!model_legal(int'(sz), int'(off))) begin
          is_err = 1;
        end else begin
          waits = 1;
          if (delay >= 1 && delay <= TMO) begin
            resp     = delay;
            exp_data = model_load(mdata, int'(sz), sgn, int'(off));
          end else begin
            resp   = TMO;
            is_err = 1;
          end
        end
      end
      default: is_err = 1;
    endcase

    check_val("ready_before", 32'(bus.o_ready), 32'd1);
    bus.i_req       = 1'b1;
    bus.i_src       = src;
    bus.i_dst       = dst;
    bus.i_alu       = alu;
    bus.i_pc        = pc;
    bus.i_ldsz      = sz;
    bus.i_ldsgn     = sgn;
    bus.i_byteoff   = off;
    bus.i_mem_valid = 1'b1;
    bus.i_mem_data  = $urandom;

    for (int e = 0; e <= resp + 1; e++) begin
      @(posedge clk);
      #1;
      check_val("wen",   32'(bus.o_wen),   32'(e == resp && !is_err && dst != 5'd0));
      check_val("done",  32'(bus.o_done),  32'(e == resp && !is_err));
      check_val("err",   32'(bus.o_err),   32'(e == resp && is_err));
      check_val("ready", 32'(bus.o_ready), 32'(e == resp + 1));
      if (e == resp && !is_err) begin
        last_wreg  = dst;
        last_wdata = exp_data;
      end
      check_val("wreg",  32'(bus.o_wreg), 32'(last_wreg));
      check_val("wdata", bus.o_wdata,     last_wdata);

      // Busy-time requests and stray valids must be ignored.
      bus.i_req     = (e <= resp) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_src     = 2'($urandom_range(0, 3));
      bus.i_dst     = 5'($urandom);
      bus.i_alu     = $urandom;
      bus.i_pc      = $urandom;
      bus.i_ldsz    = 2'($urandom_range(0, 3));
      bus.i_ldsgn   = 1'($urandom_range(0, 1));
      bus.i_byteoff = 2'($urandom_range(0, 3));
      if (waits && e + 1 <= resp) begin
        bus.i_mem_valid = (e + 1 == delay);
        bus.i_mem_data  = (e + 1 == delay) ? mdata : $urandom;
      end else begin
        bus.i_mem_valid = 1'($urandom_range(0, 1));
        bus.i_mem_data  = $urandom;
      end
    end
    bus.i_req       = 1'b0;
    bus.i_mem_valid = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    last_wreg  = '0;
    last_wdata = '0;
    bus.i_req       = 1'b0;
    bus.i_src       = '0;
    bus.i_dst       = '0;
    bus.i_alu       = '0;
    bus.i_pc        = '0;
    bus.i_ldsz      = '0;
    bus.i_ldsgn     = 1'b0;
    bus.i_byteoff   = '0;
    bus.i_mem_valid = 1'b0;
    bus.i_mem_data  = '0;

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_quiet("post_reset");

    // ALU / LINK
    run_txn(2'd0, 5'd5,  32'hDEADBEEF, 32'h0,        32'h0, 2'd0, 1'b0, 2'd0, 0);
    run_txn(2'd2, 5'd31, 32'h0,        32'h00400010, 32'h0, 2'd0, 1'b0, 2'd0, 0);
    run_txn(2'd2, 5'd0,  32'h0,        32'h00400010, 32'h0, 2'd0, 1'b0, 2'd0, 0);
    run_txn(2'd2, 5'd7,  32'h0,        32'hFFFFFFFE, 32'h0, 2'd0, 1'b0, 2'd0, 0);
    // Loads with extraction/extension
    run_txn(2'd1, 5'd3,  32'h0, 32'h0, 32'h12F45678, 2'd2, 1'b1, 2'd2, 3);
    run_txn(2'd1, 5'd3,  32'h0, 32'h0, 32'h12F45678, 2'd2, 1'b0, 2'd2, 3);
    run_txn(2'd1, 5'd4,  32'h0, 32'h0, 32'h12F45678, 2'd1, 1'b1, 2'd2, 3);
    run_txn(2'd1, 5'd4,  32'h0, 32'h0, 32'h12F4F678, 2'd1, 1'b1, 2'd0, 1);
    run_txn(2'd1, 5'd9,  32'h0, 32'h0, 32'hCAFEF00D, 2'd0, 1'b1, 2'd0, 2);
    // Errors: misaligned, reserved size, reserved source
    run_txn(2'd1, 5'd6,  32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 2'd1, 1);
    run_txn(2'd1, 5'd6,  32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 2'd3, 1);
    run_txn(2'd1, 5'd6,  32'h0, 32'h0, 32'h0, 2'd3, 1'b0, 2'd0, 1);
    run_txn(2'd3, 5'd6,  32'h1, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 0);
    // Timeout, boundary valid, one past the boundary
    run_txn(2'd1, 5'd8,  32'h0, 32'h0, 32'h11223344, 2'd0, 1'b0, 2'd0, 0);
    run_txn(2'd1, 5'd8,  32'h0, 32'h0, 32'h11223344, 2'd0, 1'b0, 2'd0, TMO);
    run_txn(2'd1, 5'd8,  32'h0, 32'h0, 32'h55667788, 2'd0, 1'b0, 2'd0, TMO + 1);

    // Reset while waiting for memory: request discarded, nothing written.
    bus.i_req     = 1'b1;
    bus.i_src     = 2'd1;
    bus.i_dst     = 5'd12;
    bus.i_ldsz    = 2'd0;
    bus.i_byteoff = 2'd0;
    @(posedge clk);
    #1;
    bus.i_req = 1'b0;
    check_val("rst_mid_ready", 32'(bus.o_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    check_quiet("rst_mid");
    bus.i_mem_valid = 1'b1;
    bus.i_mem_data  = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    bus.i_mem_valid = 1'b0;
    check_quiet("rst_mid_valid");
    last_wreg  = '0;
    last_wdata = '0;

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int r;
      int sel;
      logic [1:0] src;
      r   = $urandom_range(0, 9);
      src = (r < 3) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      sel = $urandom_range(0, 3);
      run_txn(src, 5'($urandom), $urandom, $urandom, $urandom,
              (sel == 3 && $urandom_range(0, 3) != 0) ? 2'($urandom_range(0, 2)) : 2'(sel),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              $urandom_range(0, TMO + 2));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
Writeback controller for the multi-cycle CPU. It is the write-side driver of the register file port (wreg/wdata/wen). It accepts one writeback request per instruction from the control FSM. Sources are the ALU result, a memory load (waits for memory, then byte/half extraction and extension), or a link value (PC+4). It issues exactly one single-cycle register write, or reports an error.

Parameters:
DATA_W, 32, datapath and register width
ADDR_W, 5, register address width
MEM_TIMEOUT, 255, max cycles waiting for i_mem_valid before error (1..255)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low
i_req  in  1  writeback request strobe, taken only when o_ready=1
o_ready  out  1  high in IDLE only
i_src  in  2  00 ALU, 01 LOAD, 10 LINK, 11 reserved
i_dst  in  ADDR_W  destination register
i_alu  in  DATA_W  ALU result
i_pc  in  DATA_W  current PC; LINK writes i_pc+4
i_ldsz  in  2  00 word, 01 half, 10 byte, 11 reserved
i_ldsgn  in  1  1 sign-extend, 0 zero-extend (half/byte)
i_byteoff  in  2  load address bits [1:0]
i_mem_valid  in  1  memory read data valid
i_mem_data  in  DATA_W  memory read data, little-endian
o_wreg  out  ADDR_W  register write address
o_wdata  out  DATA_W  register write data
o_wen  out  1  register write enable, one-cycle pulse
o_done  out  1  one-cycle pulse on successful completion
o_err  out  1  one-cycle pulse on error; no write occurs

Behaviour:
- Reset (rst=0 at clock edge): state IDLE; o_wen=o_done=o_err=0; o_wreg=0; o_wdata=0; timeout counter=0; any in-flight request is discarded with no write. Reset applies from any state. o_ready=1 from the first cycle after reset release.
- All outputs are registered except o_ready, which is decoded from state.
- States: IDLE, WAIT_MEM, WRITE, ERR.
- IDLE, request accepted at edge N (i_req=1): latch dst, ldsz, ldsgn, byteoff.
  - ALU: wdata<=i_alu, go to WRITE.
  - LINK: wdata<=i_pc+4 (mod 2^32), go to WRITE.
  - LOAD with valid size and alignment: go to WAIT_MEM, counter cleared.
  - LOAD with word and byteoff!=0, half and byteoff[0]=1, or ldsz=11: go to ERR.
  - src=11: go to ERR.
- Any i_mem_valid seen in IDLE is ignored.
- WAIT_MEM: i_mem_valid is sampled each cycle.
  - On valid: extract lane, then extend. Byte lane = byteoff. Half lane = byteoff[1] (0 selects [15:0], 1 selects [31:16]). Word is taken as-is. wdata is loaded, then go to WRITE.
  - Otherwise: counter increments. When the counter reaches MEM_TIMEOUT, go to ERR.
  - Valid arriving in the same cycle the counter reaches MEM_TIMEOUT wins: the load writes.
- WRITE (one cycle): o_wreg=dst, o_wdata=data, o_done=1. o_wen=1 only if dst!=0; dst=0 suppresses the write but still pulses o_done. Next state is IDLE.
- ERR (one cycle): o_err=1, o_wen=0, o_done=0. Next state is IDLE.
- Latency: ALU/LINK accepted at N gives o_wen high during cycle N+1. A load whose valid is sampled at M gives o_wen during M+1. The earliest load is M=N+1, giving o_wen at N+2.
- Throughput: at most one request per 2 cycles. o_ready=0 in WAIT_MEM, WRITE and ERR, so i_req is ignored there.
- o_wreg/o_wdata hold their last values outside WRITE; only o_wen qualifies them.

Decomposition:
- Shared package wb_pkg:
  - src codes: SRC_ALU, SRC_LOAD, SRC_LINK
  - size codes: LD_WORD, LD_HALF, LD_BYTE
  - state encoding: IDLE, WAIT_MEM, WRITE, ERR
- One combinational sub-module, load_extend. Inputs: mem_data, ldsz, ldsgn, byteoff. Output: extended 32-bit value.

Test Plan:
- ALU: i_req, src=00, dst=5, alu=0xDEADBEEF -> next cycle o_wen=1, o_wreg=5, o_wdata=0xDEADBEEF, o_done=1; o_ready low for 1 cycle.
- LINK to $31 with pc=0x00400010 -> o_wdata=0x00400014. Same request with dst=0 -> o_wen=0, o_done=1.
- LOAD byte, sign, byteoff=2, valid 3 cycles later with data 0x12F45678 -> o_wdata=0xFFFFFFF4. Zero-extend -> 0x000000F4. Half, byteoff=2, sign -> 0x000012F4.
- Misaligned: word load with byteoff=1 -> o_err one cycle after accept, no o_wen. src=11 -> same.
- Timeout with MEM_TIMEOUT=4: load accepted, no valid -> o_err pulse, back to IDLE, no write. Valid on the boundary cycle -> write occurs instead.
- Reset mid-WAIT_MEM: rst=0 for 1 cycle, then valid -> no o_wen, o_ready=1, all outputs 0.
